// File: rtl/aclock_display.sv
`default_nettype none
// ============================================================================
// Module      : aclock_display
// Description : Six-digit multiplexed 7-segment driver for the alarm clock,
//               with frame-coherent shadow capture and leading-zero blanking.
//               Optional alarm blinking is built when ACLOCK_DISPLAY_BLINK_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module aclock_display #(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic [3:0] S_in1,
    input  logic [3:0] S_in0,
    input  logic       Alarm,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp,
    output logic       frame_done
);

    localparam int            PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]    IDX_LAST   = 3'd5;

    logic [PW-1:0]    presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;
    logic [5:0][3:0]  shadow_q, shadow_d;
    logic [6:0]       seg_q, seg_d;
    logic [5:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;
    logic             w_tick;
    logic             w_blank;
    logic [3:0]       w_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    always_comb begin
        w_tick       = (presc_q == PRESC_LAST);
        presc_d      = w_tick ? '0 : presc_q + 1'b1;
        w_digit      = shadow_q[idx_q];
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        seg_d        = seg_q;
        an_d         = an_q;
        dp_d         = dp_q;
        frame_done_d = 1'b0;
        if (w_tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
            an_d  = w_blank ? 6'b000000 : (6'b000001 << idx_q);
            // Hours tens suppresses a leading zero but keeps its enable.
            seg_d = ((idx_q == IDX_LAST) && (w_digit == 4'd0)) ? 7'h00 : seg_decode(w_digit);
            dp_d  = (idx_q == 3'd2) || (idx_q == 3'd4);
            if (idx_q == IDX_LAST) begin
                shadow_d     = {{2'b00, H_in1}, H_in0, M_in1, M_in0, S_in1, S_in0};
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= '0;
            seg_q        <= 7'h00;
            an_q         <= 6'b000000;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef ACLOCK_DISPLAY_BLINK_EN
    localparam int            BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    // Counts completed frames while the alarm is active; phase flips on wrap.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (!Alarm) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (frame_done_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign w_blank = blink_q;
`else
    logic unused_alarm;
    assign unused_alarm = Alarm;
    assign w_blank      = 1'b0;
`endif

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_aclock_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_aclock_display
// Description : Self-checking bench for aclock_display against a slot/frame
//               arithmetic reference model with randomized digit stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aclock_display;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_CYC    = 6 * SCAN_DIV;
    localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] H_in1 = '0;
    logic [3:0] H_in0 = '0, M_in1 = '0, M_in0 = '0, S_in1 = '0, S_in0 = '0;
    logic       Alarm = 1'b0;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;
    logic       frame_done;

    int vectors = 0;
    int miscompares = 0;

    aclock_display #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
        .clk(clk), .reset(reset),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .S_in1(S_in1), .S_in0(S_in0), .Alarm(Alarm),
        .seg(seg), .an(an), .dp(dp), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: edges since release -> slot -> digit / frame.
    int unsigned m_edges;
    int          m_slot, m_d, m_bcnt;
    logic        m_phase, m_prev_fd;
    logic [3:0]  m_sh [6];
    logic [6:0]  exp_seg;
    logic [5:0]  exp_an;
    logic        exp_dp, exp_fd;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        if (v > 4'd9) return 7'h00;
        return SEG_TBL[v];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_edges = 0; m_bcnt = 0; m_phase = 1'b0;
            exp_seg = 7'h00; exp_an = 6'b0; exp_dp = 1'b0; exp_fd = 1'b0;
            for (int i = 0; i < 6; i++) m_sh[i] = 4'd0;
        end else begin
            m_prev_fd = exp_fd;
            m_edges++;
            exp_fd = 1'b0;
            if (m_edges % SCAN_DIV == 0) begin
                m_slot  = int'(m_edges / SCAN_DIV) - 1;
                m_d     = m_slot % 6;
                exp_an  = m_phase ? 6'b0 : 6'(1 << m_d);
                exp_seg = (m_d == 5 && m_sh[5] == 4'd0) ? 7'h00 : ref_seg(m_sh[m_d]);
                exp_dp  = (m_d == 2 || m_d == 4);
                if (m_d == 5) begin
                    m_sh[0] = S_in0; m_sh[1] = S_in1; m_sh[2] = M_in0;
                    m_sh[3] = M_in1; m_sh[4] = H_in0; m_sh[5] = {2'b00, H_in1};
                    exp_fd = 1'b1;
                end
            end
`ifdef ACLOCK_DISPLAY_BLINK_EN
            if (!Alarm) begin
                m_bcnt = 0; m_phase = 1'b0;
            end else if (m_prev_fd) begin
                m_bcnt++;
                if (m_bcnt == BLINK_FRAMES) begin
                    m_bcnt = 0; m_phase = ~m_phase;
                end
            end
`endif
        end
    end

    task automatic set_digits(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                              input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0; S_in1 = s1; S_in0 = s0;
    endtask

    task automatic randomize_digits();
        set_digits(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), 4'($urandom));
    endtask

    task automatic test_reset();
        logic [5:0] want_an;
        logic [6:0] want_seg;
        repeat (13) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({seg, an, dp, frame_done} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_async: got seg=%h an=%b dp=%b fd=%b, want all zero",
                     seg, an, dp, frame_done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= SCAN_DIV; k++) begin
            @(negedge clk);
            want_an  = (k == SCAN_DIV) ? 6'b000001 : 6'b000000;
            want_seg = (k == SCAN_DIV) ? 7'h3F : 7'h00;
            vectors++;
            if ({an, seg} !== {want_an, want_seg}) begin
                miscompares++;
                $display("FAIL first_tick edge %0d: got an=%b seg=%h, want an=%b seg=%h",
                         k, an, seg, want_an, want_seg);
            end
        end
    endtask

    task automatic test_fixed_time();
        logic [6:0] tseg [6] = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        logic       tdp  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int last_fd = 0;
        @(negedge clk);
        reset = 1'b0;
        set_digits(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 3 * FRAME_CYC; e++) begin
            @(negedge clk);
            vectors++;
            if ({seg, an, dp, frame_done} !== {exp_seg, exp_an, exp_dp, exp_fd}) begin
                miscompares++;
                $display("FAIL fixed_time edge %0d: got %h/%b/%b/%b, want %h/%b/%b/%b", e,
                         seg, an, dp, frame_done, exp_seg, exp_an, exp_dp, exp_fd);
            end
            for (int d = 0; d < 6; d++) begin
                if (e == (7 + d) * SCAN_DIV) begin
                    vectors++;
                    if ({an, seg, dp} !== {6'(1 << d), tseg[d], tdp[d]}) begin
                        miscompares++;
                        $display("FAIL 12:34:56 digit %0d: got an=%b seg=%h dp=%b, want seg=%h dp=%b",
                                 d, an, seg, dp, tseg[d], tdp[d]);
                    end
                end
            end
            if (frame_done === 1'b1) begin
                if (last_fd != 0) begin
                    vectors++;
                    if (e - last_fd != FRAME_CYC) begin
                        miscompares++;
                        $display("FAIL frame_period: got %0d cycles, want %0d", e - last_fd, FRAME_CYC);
                    end
                end
                last_fd = e;
            end
        end
    endtask

    task automatic test_blank();
        int hits = 0;
        set_digits(2'd0, 4'd9, 4'd4, 4'd2, 4'd1, 4'hC);
        repeat (2 * FRAME_CYC) begin
            @(negedge clk);
            vectors++;
            if ({seg, an, dp, frame_done} !== {exp_seg, exp_an, exp_dp, exp_fd}) begin
                miscompares++;
                $display("FAIL blank_settle: got %h/%b, want %h/%b", seg, an, exp_seg, exp_an);
            end
        end
        repeat (FRAME_CYC) begin
            @(negedge clk);
            if (an == 6'b100000 || an == 6'b000001) begin
                hits++;
                vectors++;
                if (seg !== 7'h00) begin
                    miscompares++;
                    $display("FAIL blank_digit an=%b: got seg=%h, want 00", an, seg);
                end
            end
        end
        vectors++;
        if (hits != 2 * SCAN_DIV) begin
            miscompares++;
            $display("FAIL blank_coverage: got %0d blank-slot cycles, want %0d", hits, 2 * SCAN_DIV);
        end
    endtask

    task automatic test_midframe_change();
        int guard = 0;
        while (exp_an !== 6'b000100 && guard < 4 * FRAME_CYC) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (exp_an !== 6'b000100) begin
            miscompares++;
            $display("FAIL midframe_wait: got no idx=2 slot within %0d cycles, want one", guard);
        end
        randomize_digits();
        repeat (2 * FRAME_CYC) begin
            @(negedge clk);
            vectors++;
            if ({seg, an, dp, frame_done} !== {exp_seg, exp_an, exp_dp, exp_fd}) begin
                miscompares++;
                $display("FAIL midframe: got %h/%b/%b/%b, want %h/%b/%b/%b",
                         seg, an, dp, frame_done, exp_seg, exp_an, exp_dp, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            vectors++;
            if ({seg, an, dp, frame_done} !== {exp_seg, exp_an, exp_dp, exp_fd}) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %h/%b/%b/%b, want %h/%b/%b/%b", c,
                         seg, an, dp, frame_done, exp_seg, exp_an, exp_dp, exp_fd);
            end
            if ($urandom_range(4) == 0) randomize_digits();
            if ($urandom_range(15) == 0) Alarm = ~Alarm;
        end
    endtask

    task automatic test_alarm();
        Alarm = 1'b1;
        randomize_digits();
        repeat (8 * FRAME_CYC) begin
            @(negedge clk);
            vectors++;
            if ({seg, an, dp, frame_done} !== {exp_seg, exp_an, exp_dp, exp_fd}) begin
                miscompares++;
                $display("FAIL alarm: got %h/%b/%b/%b, want %h/%b/%b/%b",
                         seg, an, dp, frame_done, exp_seg, exp_an, exp_dp, exp_fd);
            end
`ifndef ACLOCK_DISPLAY_BLINK_EN
            vectors++;
            if (an === 6'b000000) begin
                miscompares++;
                $display("FAIL alarm_no_blink: got an=%b, want nonzero", an);
            end
`endif
        end
        Alarm = 1'b0;
        repeat (FRAME_CYC) begin
            @(negedge clk);
            vectors++;
            if ({seg, an, dp, frame_done} !== {exp_seg, exp_an, exp_dp, exp_fd}) begin
                miscompares++;
                $display("FAIL alarm_off: got %h/%b, want %h/%b", seg, an, exp_seg, exp_an);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_fixed_time();
        test_blank();
        test_midframe_change();
        test_random();
        test_alarm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
